mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single SRAM port between two requesters: the CPU control unit's memory port (instruction fetch, load, store) and the program loader/debug port. It arbitrates round-robin, sequences a fixed-length SRAM access with wait states, and returns a one-cycle `ready` pulse to the granted requester. Sits between the core/loader and the SRAM pins; the core stalls its state counter until `cpu_ready`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `WAIT_CYCLES`, 2, SRAM access cycles per transfer (legal range 1..15)

- `clk`  in  1  system clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high
- `cpu_req`  in  1  CPU request; held with `cpu_we`/`cpu_addr`/`cpu_wdata` stable until `cpu_ready`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  last CPU read data (held)
- `cpu_ready`  out  1  one-cycle completion pulse
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_rdata`, `ldr_ready`  same as CPU set, loader side
- `ldr_lock`  in  1  while high, CPU is never granted
- `sram_ce`  out  1  chip enable
- `sram_we`  out  1  write enable
- `sram_oe`  out  1  output enable
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_wdata`  out  DATA_W  SRAM write data
- `sram_rdata`  in  DATA_W  SRAM read data
- `grant_ldr`  out  1  1 while loader owns the current/last access

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: `sram_*` strobes low. At posedge, if any eligible request: pick winner, latch its `we`/`addr`/`wdata` into internal registers, load wait counter with WAIT_CYCLES-1, go ACCESS.
- Eligibility: `cpu_req & !ldr_lock`; `ldr_req`.
- Arbitration: single requester wins; both eligible -> the one NOT served last (`last_ldr` flag). `last_ldr` updated on every grant.
- ACCESS: `sram_ce`=1, `sram_oe`=!we, `sram_we`=we, `sram_addr`/`sram_wdata` from latched registers (not live inputs). Counter decrements each cycle; at 0: if read, capture `sram_rdata` into winner's `rdata` register; go DONE.
- DONE: winner's `ready`=1 for exactly this cycle, strobes low; unconditionally go IDLE.
- Writes leave both `rdata` registers unchanged. Non-winner's `rdata` never changes.
- Request deasserted mid-access: access still completes and `ready` still pulses (requester protocol violation; no abort).
- `ldr_lock` rising mid CPU access: current access completes; takes effect at next arbitration.
- `grant_ldr` set at grant, held through IDLE until next grant.

## Timing
- Reset values: state IDLE, all strobes 0, `cpu_ready`=`ldr_ready`=0, `cpu_rdata`=`ldr_rdata`=0, `sram_addr`=`sram_wdata`=0, `grant_ldr`=0, `last_ldr`=1 (CPU wins first tie).
- Reset mid-ACCESS/DONE: next cycle IDLE with reset values; no `ready` pulse for the aborted transfer.
- Request seen at edge t -> ACCESS cycles t+1..t+WAIT_CYCLES -> `ready` high in cycle t+WAIT_CYCLES+1.
- `sram_rdata` sampled at the last ACCESS posedge; `rdata` valid from the `ready` cycle onward.
- Back-to-back throughput: one transfer per WAIT_CYCLES+2 cycles (DONE->IDLE bubble mandatory).
- Requester may deassert or change request in the `ready` cycle; DONE never re-samples requests.

## Test plan
- CPU read, WAIT_CYCLES=2, addr 0x100, SRAM model returns 0xDEADBEEF -> `sram_ce`/`sram_oe` high 2 cycles, `cpu_ready` 3 cycles after request edge, `cpu_rdata`=0xDEADBEEF, `ldr_rdata`=0.
- Both requesting continuously from reset -> grant order CPU, LDR, CPU, LDR; `ready` pulses every 4 cycles alternating.
- `ldr_lock`=1 with both requesting -> only loader granted for 5 transfers; drop lock -> CPU granted next.
- Loader write 0x12345678 to 0x40, then CPU read 0x40 -> `sram_we` high only during loader ACCESS; `cpu_rdata`=0x12345678.
- `reset` in the first ACCESS cycle of a CPU read -> following cycle all strobes 0, no `cpu_ready`, `cpu_rdata`=0; re-request completes normally.
- CPU changes `cpu_addr` from 0x10 to 0x20 mid-ACCESS -> `sram_addr` stays 0x10 for the whole access.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and SRAM pin bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_ready;
    logic              ldr_lock;

    logic              sram_ce;
    logic              sram_we;
    logic              sram_oe;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              grant_ldr;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output ldr_rdata, ldr_ready,
        output sram_ce, sram_we, sram_oe, sram_addr, sram_wdata,
        input  sram_rdata,
        output grant_ldr
    );

    // Requester / SRAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  ldr_rdata, ldr_ready,
        input  sram_ce, sram_we, sram_oe, sram_addr, sram_wdata,
        output sram_rdata,
        input  grant_ldr
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/loader arbiter sequencing fixed-length SRAM accesses
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              grant_ldr_q, grant_ldr_d;
    logic              last_ldr_q, last_ldr_d;
    logic              cpu_elig;
    logic              pick_ldr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            grant_ldr_q <= 1'b0;
            // CPU wins the first tie after reset
            last_ldr_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            grant_ldr_q <= grant_ldr_d;
            last_ldr_q  <= last_ldr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        grant_ldr_d = grant_ldr_q;
        last_ldr_d  = last_ldr_q;
        cpu_elig    = bus.cpu_req & ~bus.ldr_lock;
        pick_ldr    = bus.ldr_req & (~cpu_elig | ~last_ldr_q);

        case (state_q)
            IDLE: begin
                if (cpu_elig | bus.ldr_req) begin
                    grant_ldr_d = pick_ldr;
                    last_ldr_d  = pick_ldr;
                    we_d        = pick_ldr ? bus.ldr_we    : bus.cpu_we;
                    addr_d      = pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
                    wdata_d     = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                    cnt_d       = CNT_INIT;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Read data is captured on the last access edge only
                    if (!we_q) begin
                        if (grant_ldr_q) ldr_rdata_d = bus.sram_rdata;
                        else             cpu_rdata_d = bus.sram_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.sram_ce    = (state_q == ACCESS);
    assign bus.sram_we    = (state_q == ACCESS) & we_q;
    assign bus.sram_oe    = (state_q == ACCESS) & ~we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ldr_rdata  = ldr_rdata_q;
    assign bus.cpu_ready  = (state_q == DONE) & ~grant_ldr_q;
    assign bus.ldr_ready  = (state_q == DONE) & grant_ldr_q;
    assign bus.grant_ldr  = grant_ldr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: word i holds i, except two preset read locations
    logic [31:0] mem [0:1023];
    bit          mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
            mem[10'h100] <= 32'hDEADBEEF;
            mem[10'h200] <= 32'hA5A50001;
            mem_init     <= 1'b1;
        end else if (bus.sram_ce && bus.sram_we) begin
            mem[bus.sram_addr[9:0]] <= bus.sram_wdata;
        end
    end
    assign bus.sram_rdata = mem[bus.sram_addr[9:0]];

    task automatic test_reset();
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = 0; bus.ldr_wdata = 0;
        bus.ldr_lock = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.sram_ce !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b expected 0", bus.sram_ce); end
        n_checks++; if ({bus.sram_we, bus.sram_oe} !== 2'b00) begin n_fail++; $display("FAIL rst_we_oe: got %b expected 00", {bus.sram_we, bus.sram_oe}); end
        n_checks++; if ({bus.cpu_ready, bus.ldr_ready, bus.grant_ldr} !== 3'b000) begin n_fail++; $display("FAIL rst_ready_grant: got %b expected 000", {bus.cpu_ready, bus.ldr_ready, bus.grant_ldr}); end
        n_checks++; if (bus.cpu_rdata !== 32'h0 || bus.ldr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h expected 0/0", bus.cpu_rdata, bus.ldr_rdata); end
        n_checks++; if (bus.sram_addr !== 32'h0 || bus.sram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_addr_wdata: got %h/%h expected 0/0", bus.sram_addr, bus.sram_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h100;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++; if ({bus.sram_ce, bus.sram_oe} !== ((i <= 2) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL rd_ce_oe[%0d]: got %b expected %b", i, {bus.sram_ce, bus.sram_oe}, (i <= 2) ? 2'b11 : 2'b00); end
            n_checks++; if (bus.cpu_ready !== (i == 3)) begin n_fail++; $display("FAIL rd_ready[%0d]: got %b expected %b", i, bus.cpu_ready, i == 3); end
            if (i == 1) begin
                n_checks++; if (bus.sram_addr !== 32'h100 || bus.sram_we !== 1'b0) begin n_fail++; $display("FAIL rd_addr: got %h we=%b expected 100 we=0", bus.sram_addr, bus.sram_we); end
            end
            if (i == 3) begin
                n_checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_cpu_rdata: got %h expected deadbeef", bus.cpu_rdata); end
                n_checks++; if (bus.ldr_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_ldr_rdata: got %h expected 0", bus.ldr_rdata); end
                bus.cpu_req = 0;
            end
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h100;
        bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 32'h200;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            n_checks++; if (bus.cpu_ready !== (i == 3 || i == 11)) begin n_fail++; $display("FAIL rr_cpu_ready[%0d]: got %b expected %b", i, bus.cpu_ready, (i == 3 || i == 11)); end
            n_checks++; if (bus.ldr_ready !== (i == 7 || i == 15)) begin n_fail++; $display("FAIL rr_ldr_ready[%0d]: got %b expected %b", i, bus.ldr_ready, (i == 7 || i == 15)); end
            n_checks++; if (bus.grant_ldr !== 1'(((i - 1) / 4) % 2)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %0d", i, bus.grant_ldr, ((i - 1) / 4) % 2); end
            if (i == 7) begin
                n_checks++; if (bus.ldr_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL rr_ldr_rdata: got %h expected a5a50001", bus.ldr_rdata); end
            end
            if (i == 16) begin bus.cpu_req = 0; bus.ldr_req = 0; end
        end
    endtask

    task automatic test_lock();
        bus.cpu_req = 1; bus.ldr_req = 1; bus.ldr_lock = 1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            n_checks++; if (bus.ldr_ready !== (i % 4 == 3 && i <= 19)) begin n_fail++; $display("FAIL lk_ldr_ready[%0d]: got %b expected %b", i, bus.ldr_ready, (i % 4 == 3 && i <= 19)); end
            n_checks++; if (bus.cpu_ready !== (i == 23)) begin n_fail++; $display("FAIL lk_cpu_ready[%0d]: got %b expected %b", i, bus.cpu_ready, i == 23); end
            n_checks++; if (bus.grant_ldr !== (i <= 20)) begin n_fail++; $display("FAIL lk_grant[%0d]: got %b expected %b", i, bus.grant_ldr, i <= 20); end
            if (i == 20) bus.ldr_lock = 0;
            if (i == 23) begin bus.cpu_req = 0; bus.ldr_req = 0; end
        end
    endtask

    task automatic test_write_then_read();
        bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 32'h40; bus.ldr_wdata = 32'h12345678;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++; if (bus.sram_we !== (i <= 2)) begin n_fail++; $display("FAIL wr_sram_we[%0d]: got %b expected %b", i, bus.sram_we, i <= 2); end
            n_checks++; if (bus.sram_oe !== (i == 5 || i == 6)) begin n_fail++; $display("FAIL wr_sram_oe[%0d]: got %b expected %b", i, bus.sram_oe, (i == 5 || i == 6)); end
            if (i == 1) begin
                n_checks++; if (bus.sram_wdata !== 32'h12345678 || bus.sram_addr !== 32'h40) begin n_fail++; $display("FAIL wr_bus: got %h@%h expected 12345678@40", bus.sram_wdata, bus.sram_addr); end
            end
            if (i == 3) begin
                n_checks++; if (bus.ldr_ready !== 1'b1 || bus.ldr_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL wr_done: got ready=%b rdata=%h expected 1/a5a50001", bus.ldr_ready, bus.ldr_rdata); end
                bus.ldr_req = 0; bus.ldr_we = 0;
                bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h40;
            end
            if (i == 7) begin
                n_checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_readback: got ready=%b rdata=%h expected 1/12345678", bus.cpu_ready, bus.cpu_rdata); end
                n_checks++; if (bus.ldr_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL wr_ldr_keep: got %h expected a5a50001", bus.ldr_rdata); end
                bus.cpu_req = 0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h100;
        @(negedge clk);
        n_checks++; if (bus.sram_ce !== 1'b1) begin n_fail++; $display("FAIL rm_access: got ce=%b expected 1", bus.sram_ce); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if ({bus.sram_ce, bus.sram_we, bus.sram_oe} !== 3'b000) begin n_fail++; $display("FAIL rm_strobes: got %b expected 000", {bus.sram_ce, bus.sram_we, bus.sram_oe}); end
        n_checks++; if (bus.cpu_ready !== 1'b0 || bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_cleared: got ready=%b rdata=%h expected 0/0", bus.cpu_ready, bus.cpu_rdata); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++; if (bus.cpu_ready !== (i == 3)) begin n_fail++; $display("FAIL rm_ready[%0d]: got %b expected %b", i, bus.cpu_ready, i == 3); end
            if (i == 3) begin
                n_checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rm_rdata: got %h expected deadbeef", bus.cpu_rdata); end
                bus.cpu_req = 0;
            end
        end
    endtask

    task automatic test_addr_hold();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i <= 2) begin
                n_checks++; if (bus.sram_addr !== 32'h10) begin n_fail++; $display("FAIL ah_addr[%0d]: got %h expected 10", i, bus.sram_addr); end
            end
            if (i == 1) bus.cpu_addr = 32'h20;
            if (i == 3) begin
                n_checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 32'h10) begin n_fail++; $display("FAIL ah_rdata: got ready=%b rdata=%h expected 1/10", bus.cpu_ready, bus.cpu_rdata); end
                bus.cpu_req = 0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_lock();
        test_write_then_read();
        test_reset_mid_access();
        test_addr_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
